// File: rtl/demux_vc_pkg.sv
// Shared definitions for the VC demultiplexer: VC identifiers, default
// flit geometry, holding-buffer depth and the occupancy type used by
// both the top level and the per-VC buffer.
package demux_vc_pkg;

  localparam int VC0_ID        = 0;
  localparam int VC1_ID        = 1;

  localparam int DEF_BITNUMBER = 6;
  localparam int DEF_SEL_BIT   = 4;
  localparam int DEF_CNT_W     = 8;

  localparam int VC_DEPTH      = 2;
  localparam int OCC_W         = $clog2(VC_DEPTH + 1);
  localparam int PTR_W         = $clog2(VC_DEPTH);

  typedef logic [OCC_W-1:0] occ_t;

  localparam occ_t OCC_FULL    = occ_t'(VC_DEPTH);

  function automatic logic buf_full(input occ_t occ);
    return occ == OCC_FULL;
  endfunction

endpackage

// File: rtl/vc_skid_fifo.sv
// Purpose  : 2-entry holding buffer for one VC with a registered output stage.
// Latency  : flit pushed at edge N is emitted at edge N+1 at the earliest (no bypass).
// Backpress: pause holds the head entry and drives a zero/invalid output; the
//            producer must not push while occ reports full.
// Ports    : clk, reset (async active-low); push/push_data write an entry;
//            pause stalls emission; occ is the registered occupancy; pop
//            flags an emission this cycle; data_out/valid_out are registered.
module vc_skid_fifo
  import demux_vc_pkg::*;
#(
  parameter int W = DEF_BITNUMBER
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pause,
  output occ_t         occ,
  output logic         pop,
  output logic [W-1:0] data_out,
  output logic         valid_out
);

  logic [VC_DEPTH-1:0][W-1:0] mem;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;

  // Emission looks only at registered occupancy, so a flit pushed this
  // edge into an empty buffer cannot leave until the following edge.
  assign pop = (occ != '0) && !pause;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end

      if (pop) begin
        data_out  <= mem[rd_ptr];
        valid_out <= 1'b1;
        rd_ptr    <= rd_ptr + PTR_W'(1);
      end else begin
        data_out  <= '0;
        valid_out <= 1'b0;
      end

      case ({push, pop})
        2'b10:   occ <= occ + occ_t'(1);
        2'b01:   occ <= occ - occ_t'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/demux_vc.sv
// Purpose  : split one flit stream into VC0/VC1 by a routing bit, counting delivered flits.
// Latency  : 2 edges from presentation to valid output on an empty, unpaused VC; 1 flit/cycle.
// Backpress: ready_in drops whenever either VC buffer is full, regardless of the flit's VC.
// Ports    : clk, reset (async active-low); data_in/valid_in/ready_in input
//            handshake; pause_vc0/1 from the downstream FIFOs; data_out0/1 and
//            valid_out0/1 registered per-VC outputs; cnt_vc0/1 emitted-flit counts.
module demux_vc
  import demux_vc_pkg::*;
#(
  parameter int BITNUMBER = DEF_BITNUMBER,
  parameter int SEL_BIT   = DEF_SEL_BIT,   // must be < BITNUMBER
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BITNUMBER-1:0] data_in,
  input  logic                 valid_in,
  output logic                 ready_in,
  input  logic                 pause_vc0,
  input  logic                 pause_vc1,
  output logic [BITNUMBER-1:0] data_out0,
  output logic                 valid_out0,
  output logic [BITNUMBER-1:0] data_out1,
  output logic                 valid_out1,
  output logic [CNT_W-1:0]     cnt_vc0,
  output logic [CNT_W-1:0]     cnt_vc1
);

  localparam logic VC1_SEL = 1'(VC1_ID);

  occ_t occ0;
  occ_t occ1;
  logic pop0;
  logic pop1;
  logic accept;
  logic to_vc1;

  // Deliberately conservative: one full VC stalls the whole input so the
  // ready path never depends on data_in.
  assign ready_in = !buf_full(occ0) && !buf_full(occ1);
  assign accept   = valid_in && ready_in;
  assign to_vc1   = (data_in[SEL_BIT] == VC1_SEL);

  vc_skid_fifo #(.W(BITNUMBER)) u_vc0 (
    .clk       (clk),
    .reset     (reset),
    .push      (accept && !to_vc1),
    .push_data (data_in),
    .pause     (pause_vc0),
    .occ       (occ0),
    .pop       (pop0),
    .data_out  (data_out0),
    .valid_out (valid_out0)
  );

  vc_skid_fifo #(.W(BITNUMBER)) u_vc1 (
    .clk       (clk),
    .reset     (reset),
    .push      (accept && to_vc1),
    .push_data (data_in),
    .pause     (pause_vc1),
    .occ       (occ1),
    .pop       (pop1),
    .data_out  (data_out1),
    .valid_out (valid_out1)
  );

  // Counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_vc0 <= '0;
      cnt_vc1 <= '0;
    end else begin
      if (pop0) cnt_vc0 <= cnt_vc0 + CNT_W'(1);
      if (pop1) cnt_vc1 <= cnt_vc1 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_demux_vc.sv
module tb_demux_vc;

  localparam int SEL = 4;

  logic       clk;
  logic       reset;
  logic [5:0] data_in;
  logic       valid_in;
  logic       ready_in;
  logic       pause_vc0;
  logic       pause_vc1;
  logic [5:0] data_out0;
  logic       valid_out0;
  logic [5:0] data_out1;
  logic       valid_out1;
  logic [7:0] cnt_vc0;
  logic [7:0] cnt_vc1;

  demux_vc dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .pause_vc0  (pause_vc0),
    .pause_vc1  (pause_vc1),
    .data_out0  (data_out0),
    .valid_out0 (valid_out0),
    .data_out1  (data_out1),
    .valid_out1 (valid_out1),
    .cnt_vc0    (cnt_vc0),
    .cnt_vc1    (cnt_vc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;
  bit mon_en   = 1'b0;

  // Reference model: per-VC holding buffers (b*), flits predicted to appear
  // on the outputs this cycle (e*), and delivered-flit counts.
  logic [5:0] b0[$];
  logic [5:0] b1[$];
  logic [5:0] e0[$];
  logic [5:0] e1[$];
  logic [7:0] m_cnt0 = 8'd0;
  logic [7:0] m_cnt1 = 8'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    bit rdy;
    if (!reset) begin
      b0.delete(); b1.delete(); e0.delete(); e1.delete();
      m_cnt0 = 8'd0;
      m_cnt1 = 8'd0;
    end else begin
      rdy = (b0.size() < 2) && (b1.size() < 2);
      if (b0.size() > 0 && !pause_vc0) begin e0.push_back(b0.pop_front()); m_cnt0++; end
      if (b1.size() > 0 && !pause_vc1) begin e1.push_back(b1.pop_front()); m_cnt1++; end
      if (valid_in && rdy) begin
        if (data_in[SEL]) b1.push_back(data_in);
        else              b0.push_back(data_in);
        acc_cnt++;
      end
    end
  end

  // Monitor: compares every cycle's outputs against the model's predictions.
  always @(negedge clk) begin
    logic [5:0] exp_d;
    if (mon_en) begin
      chk("ready_in", 32'(ready_in), 32'((b0.size() < 2) && (b1.size() < 2)));
      chk("cnt_vc0", 32'(cnt_vc0), 32'(m_cnt0));
      chk("cnt_vc1", 32'(cnt_vc1), 32'(m_cnt1));
      chk("valid_out0", 32'(valid_out0), 32'(e0.size() != 0));
      if (e0.size() != 0) begin
        exp_d = e0.pop_front();
        if (valid_out0) chk("data_out0", 32'(data_out0), 32'(exp_d));
      end else chk("idle_data_out0", 32'(data_out0), 32'd0);
      chk("valid_out1", 32'(valid_out1), 32'(e1.size() != 0));
      if (e1.size() != 0) begin
        exp_d = e1.pop_front();
        if (valid_out1) chk("data_out1", 32'(data_out1), 32'(exp_d));
      end else chk("idle_data_out1", 32'(data_out1), 32'd0);
    end
  end

  task automatic wait_acc(input int start, input int max, input string nm);
    int k;
    k = 0;
    while (acc_cnt == start && k < max) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (acc_cnt == start) begin
      n_fail++;
      $display("FAIL %s: accepted=0 expected accepted=1 within %0d cycles", nm, max);
    end
    valid_in = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic send(input logic [5:0] f, input string nm);
    int s;
    s = acc_cnt;
    data_in  = f;
    valid_in = 1'b1;
    @(negedge clk);
    wait_acc(s, 300, nm);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((b0.size() + b1.size() + e0.size() + e1.size()) != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
  endtask

  initial begin
    int s;
    int sent;
    logic [5:0] got[$];
    logic [5:0] exp_p[3];

    reset = 1'b0; valid_in = 1'b0; data_in = '0;
    pause_vc0 = 1'b0; pause_vc1 = 1'b0;
    exp_p[0] = 6'h01; exp_p[1] = 6'h02; exp_p[2] = 6'h03;

    // Reset / idle
    repeat (3) @(negedge clk);
    chk("rst_valid_out0", 32'(valid_out0), 32'd0);
    chk("rst_valid_out1", 32'(valid_out1), 32'd0);
    chk("rst_data_out0", 32'(data_out0), 32'd0);
    chk("rst_data_out1", 32'(data_out1), 32'd0);
    chk("rst_cnt_vc0", 32'(cnt_vc0), 32'd0);
    chk("rst_cnt_vc1", 32'(cnt_vc1), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_ready_in", 32'(ready_in), 32'd1);
    chk("idle_valid_out0", 32'(valid_out0), 32'd0);
    mon_en = 1'b1;

    // Routing and two-edge latency
    data_in = 6'h05; valid_in = 1'b1;
    @(negedge clk);
    chk("route_lat_early", 32'(valid_out0), 32'd0);
    data_in = 6'h15;
    @(negedge clk);
    valid_in = 1'b0;
    chk("route_v0", 32'(valid_out0), 32'd1);
    chk("route_d0", 32'(data_out0), 32'h05);
    chk("route_v1_early", 32'(valid_out1), 32'd0);
    @(negedge clk);
    chk("route_v1", 32'(valid_out1), 32'd1);
    chk("route_d1", 32'(data_out1), 32'h15);
    chk("route_cnt0", 32'(cnt_vc0), 32'd1);
    chk("route_cnt1", 32'(cnt_vc1), 32'd1);

    // Pause / backpressure on VC0
    pause_vc0 = 1'b1;
    send(6'h01, "pause_01");
    send(6'h02, "pause_02");
    s = acc_cnt; data_in = 6'h03; valid_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("pause_ready_low", 32'(ready_in), 32'd0);
    chk("pause_no_emit", 32'(valid_out0), 32'd0);
    pause_vc0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (valid_out0) got.push_back(data_out0);
      if (acc_cnt != s) valid_in = 1'b0;
    end
    chk("pause_order_len", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3 && i < got.size(); i++)
      chk("pause_order", 32'(got[i]), 32'(exp_p[i]));

    // Cross-VC blocking: full VC1 stalls a VC0 flit
    pause_vc1 = 1'b1;
    send(6'h10, "xvc_10");
    send(6'h11, "xvc_11");
    s = acc_cnt; data_in = 6'h0A; valid_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("xvc_ready_low", 32'(ready_in), 32'd0);
    chk("xvc_vc0_quiet", 32'(valid_out0), 32'd0);
    pause_vc1 = 1'b0;
    wait_acc(s, 20, "xvc_0a");
    drain();
    chk("xvc_cnt0", 32'(cnt_vc0), 32'd5);
    chk("xvc_cnt1", 32'(cnt_vc1), 32'd3);

    // Randomized traffic with random pauses
    sent = 0; s = acc_cnt;
    for (int c = 0; c < 4000 && sent < 300; c++) begin
      pause_vc0 = ($urandom_range(0, 1) == 0);
      pause_vc1 = ($urandom_range(0, 2) == 0);
      if (valid_in && acc_cnt != s) begin valid_in = 1'b0; sent++; end
      if (!valid_in && $urandom_range(0, 4) != 0) begin
        s = acc_cnt;
        data_in  = 6'($urandom_range(0, 63));
        valid_in = 1'b1;
      end
      @(negedge clk);
    end
    if (valid_in) wait_acc(s, 10, "rand_tail");
    valid_in = 1'b0; pause_vc0 = 1'b0; pause_vc1 = 1'b0;
    drain();

    // Async reset mid-stream with both buffers occupied
    pause_vc0 = 1'b1; pause_vc1 = 1'b1;
    send(6'h02, "ar_02");
    send(6'h12, "ar_12");
    send(6'h03, "ar_03");
    pause_vc0 = 1'b0; pause_vc1 = 1'b0;
    @(negedge clk);
    chk("ar_pre_v0", 32'(valid_out0), 32'd1);
    chk("ar_pre_v1", 32'(valid_out1), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_v0_immediate", 32'(valid_out0), 32'd0);
    chk("ar_v1_immediate", 32'(valid_out1), 32'd0);
    chk("ar_cnt0", 32'(cnt_vc0), 32'd0);
    chk("ar_cnt1", 32'(cnt_vc1), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(6'h07, "ar_post_07");
    drain();
    chk("ar_post_cnt0", 32'(cnt_vc0), 32'd1);
    chk("ar_post_cnt1", 32'(cnt_vc1), 32'd0);

    // Counter wrap: 256 flits to VC1
    for (int i = 0; i < 256; i++)
      send(6'(i) | 6'h10, "wrap_send");
    drain();
    chk("wrap_cnt1", 32'(cnt_vc1), 32'd0);
    chk("wrap_cnt0", 32'(cnt_vc0), 32'd1);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
